// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared types and constants for the Avalon RAM model
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } ram_state_t;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting left with feedback into bit 0
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/wait_lfsr.sv
// rtl/wait_lfsr.sv - 8-bit Fibonacci LFSR that steps once per advance strobe
module wait_lfsr
  import cpu_bus_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] value
);

  logic [7:0] value_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= SEED;
    end else if (advance) begin
      value_q <= lfsr_step(value_q);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/avalon_ram_wait.sv
// rtl/avalon_ram_wait.sv - Avalon-MM slave RAM with fixed or pseudo-random wait states
module avalon_ram_wait
  import cpu_bus_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_MODE   = 0,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [7:0]        LFSR_SEED   = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [WORD_W-1:0] writedata,
  input  logic [BE_W-1:0]   byteenable,
  output logic              waitrequest,
  output logic [WORD_W-1:0] readdata,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WORD_W-1:0] load_data,
  output logic              bus_error
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_MAX = 4'(WAIT_CYCLES);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  ram_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [WORD_W-1:0] readdata_q;
  logic              err_q;

  logic              req, accept, go_ack, abort;
  logic [7:0]        lfsr_val;
  logic [3:0]        lfsr_w, w_load;
  logic [ADDR_W-1:0] bus_word, load_word;
  logic              bus_legal, load_legal;
  logic [IDX_W-1:0]  bus_idx, load_idx;
  logic              eff_write;
  logic [WORD_W-1:0] eff_wdata;
  logic [BE_W-1:0]   eff_be;
  logic              unused_bits;

  generate
    if (WAIT_MODE == 1) begin : g_lfsr
      wait_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (accept),
        .value   (lfsr_val)
      );
    end else begin : g_fixed
      assign lfsr_val = LFSR_SEED;
    end
  endgenerate

  assign lfsr_w = (lfsr_val[3:0] > WAIT_MAX) ? WAIT_MAX : lfsr_val[3:0];
  assign w_load = (WAIT_MODE == 1) ? lfsr_w : WAIT_MAX;

  assign bus_word   = (address - BASE_ADDR) >> 2;
  assign load_word  = (load_addr - BASE_ADDR) >> 2;
  assign bus_legal  = (address[1:0] == 2'b00) && (bus_word < ADDR_W'(DEPTH_WORDS));
  assign load_legal = (load_addr[1:0] == 2'b00) && (load_word < ADDR_W'(DEPTH_WORDS));
  assign bus_idx    = bus_word[IDX_W-1:0];
  assign load_idx   = load_word[IDX_W-1:0];
  assign unused_bits = ^lfsr_val[7:4];

  // An ACK entered from WAIT implies the live address still equals addr_q
  assign eff_write = (state_q == IDLE) ? write      : wr_q;
  assign eff_wdata = (state_q == IDLE) ? writedata  : wdata_q;
  assign eff_be    = (state_q == IDLE) ? byteenable : be_q;

  assign req         = read | write;
  assign waitrequest = req & (state_q != ACK);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    go_ack  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (w_load == 4'd0) begin
            state_d = ACK;
            go_ack  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = w_load - 4'd1;
          end
        end
      end
      WAIT: begin
        if (!req || (address != addr_q)) begin
          state_d = IDLE;
          abort   = 1'b1;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
          go_ack  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      readdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= address;
        wr_q    <= write;
        wdata_q <= writedata;
        be_q    <= byteenable;
      end
      if ((accept && ((read && write) || !bus_legal)) || abort || (load_en && !load_legal)) begin
        err_q <= 1'b1;
      end
      if (go_ack && !eff_write) begin
        readdata_q <= bus_legal ? mem[bus_idx] : '0;
      end
    end
  end

  // No reset here: contents survive reset and the load port works during it
  always_ff @(posedge clk) begin
    if (go_ack && eff_write && bus_legal && !reset) begin
      for (int b = 0; b < BE_W; b++) begin
        if (eff_be[b]) mem[bus_idx][8*b +: 8] <= eff_wdata[8*b +: 8];
      end
    end
    if (load_en && load_legal) begin
      mem[load_idx] <= load_data;
    end
  end

  assign readdata  = readdata_q;
  assign bus_error = err_q;

endmodule

// File: tb/tb_avalon_ram_wait.sv
// tb/tb_avalon_ram_wait.sv - directed vector bench for avalon_ram_wait in four configurations
module tb_avalon_ram_wait;

  logic        clk;
  logic        reset;
  logic [31:0] address, writedata, load_addr, load_data;
  logic [3:0]  byteenable;
  logic        read, write, load_en;
  int          sel;

  logic [3:0]  rd_v, wr_v, ld_v;
  logic [3:0]  wreq, berr;
  logic [31:0] rdata [4];

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          w;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          stall;
    logic [31:0] rd;
    bit          err;
  } vec_t;

  vec_t tbl [11];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_v[k] = read && (sel == k);
      wr_v[k] = write && (sel == k);
      ld_v[k] = load_en && (sel == k);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  avalon_ram_wait #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .address(address), .read(rd_v[0]), .write(wr_v[0]),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(wreq[0]), .readdata(rdata[0]),
    .load_en(ld_v[0]), .load_addr(load_addr), .load_data(load_data), .bus_error(berr[0]));

  avalon_ram_wait #(.WAIT_CYCLES(3)) u1 (
    .clk(clk), .reset(reset), .address(address), .read(rd_v[1]), .write(wr_v[1]),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(wreq[1]), .readdata(rdata[1]),
    .load_en(ld_v[1]), .load_addr(load_addr), .load_data(load_data), .bus_error(berr[1]));

  avalon_ram_wait #(.WAIT_CYCLES(5)) u2 (
    .clk(clk), .reset(reset), .address(address), .read(rd_v[2]), .write(wr_v[2]),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(wreq[2]), .readdata(rdata[2]),
    .load_en(ld_v[2]), .load_addr(load_addr), .load_data(load_data), .bus_error(berr[2]));

  avalon_ram_wait #(.BASE_ADDR(32'h1000), .WAIT_MODE(1), .WAIT_CYCLES(7), .LFSR_SEED(8'hA5)) u3 (
    .clk(clk), .reset(reset), .address(address), .read(rd_v[3]), .write(wr_v[3]),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(wreq[3]), .readdata(rdata[3]),
    .load_en(ld_v[3]), .load_addr(load_addr), .load_data(load_data), .bus_error(berr[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic load(input int k, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = k; load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // One bus access; stall = cycles with waitrequest high, rd = readdata in the ACK cycle
  task automatic access(input int k, input bit w, input bit both, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output int stall, output logic [31:0] rd);
    @(negedge clk);
    sel = k; address = a; writedata = d; byteenable = be;
    write = w; read = !w || both;
    stall = 0;
    #1;
    while (wreq[k] && stall < 40) begin
      stall++;
      @(negedge clk);
      #1;
    end
    if (stall >= 40) begin
      bad++; total++;
      $display("FAIL access_timeout: got stall %0d want under 40", stall);
    end
    rd = rdata[k];
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    int          stall;
    logic [31:0] rd;
    logic [7:0]  m;
    int          w;

    reset = 1'b1; read = 1'b0; write = 1'b0; load_en = 1'b0; sel = 0;
    address = '0; writedata = '0; byteenable = '0; load_addr = '0; load_data = '0;

    load(0, 32'h04, 32'h24020010);
    load(1, 32'h00, 32'h0BADF00D);
    load(1, 32'h10, 32'h00000000);
    load(2, 32'h20, 32'h01010101);
    for (int i = 0; i < 20; i++) load(3, 32'h1000 + 32'(i * 4), 32'hC0DE0000 | 32'(i));
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("reset_waitreq", {31'b0, wreq[k]}, 32'h0);
      chk("reset_readdata", rdata[k], 32'h0);
      chk("reset_bus_error", {31'b0, berr[k]}, 32'h0);
    end

    access(0, 1'b0, 1'b0, 32'h04, 32'h0, 4'hF, stall, rd);
    chk("w0_stall", stall, 1);
    chk("w0_preload_data", rd, 32'h24020010);

    @(negedge clk);
    sel = 0; address = 32'h08; writedata = 32'h22222222; byteenable = 4'hF; write = 1'b1;
    load_en = 1'b1; load_addr = 32'h08; load_data = 32'h11111111;
    @(posedge clk); #1;
    load_en = 1'b0;
    @(posedge clk); #1;
    write = 1'b0;
    access(0, 1'b0, 1'b0, 32'h08, 32'h0, 4'hF, stall, rd);
    chk("collision_data", rd, 32'h11111111);
    chk("collision_no_err", {31'b0, berr[0]}, 32'h0);

    load(0, 32'h403, 32'hFFFFFFFF);
    #1;
    chk("bad_load_err", {31'b0, berr[0]}, 32'h1);

    access(0, 1'b1, 1'b1, 32'h0C, 32'h5555AAAA, 4'hF, stall, rd);
    access(0, 1'b0, 1'b0, 32'h0C, 32'h0, 4'hF, stall, rd);
    chk("rw_both_as_write", rd, 32'h5555AAAA);

    tbl[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 4'b0101, 4, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 32'h010, 32'h0,        4'b1111, 4, 32'h00AD00EF, 1'b0};
    tbl[2]  = '{1'b1, 32'h014, 32'hCAFEF00D, 4'b1111, 4, 32'h00AD00EF, 1'b0};
    tbl[3]  = '{1'b0, 32'h014, 32'h0,        4'b1111, 4, 32'hCAFEF00D, 1'b0};
    tbl[4]  = '{1'b1, 32'h014, 32'h12345678, 4'b1000, 4, 32'hCAFEF00D, 1'b0};
    tbl[5]  = '{1'b0, 32'h014, 32'h0,        4'b1111, 4, 32'h12FEF00D, 1'b0};
    tbl[6]  = '{1'b1, 32'h3FC, 32'hA5A5A5A5, 4'b1111, 4, 32'h12FEF00D, 1'b0};
    tbl[7]  = '{1'b0, 32'h3FC, 32'h0,        4'b1111, 4, 32'hA5A5A5A5, 1'b0};
    tbl[8]  = '{1'b0, 32'h402, 32'h0,        4'b1111, 4, 32'h00000000, 1'b1};
    tbl[9]  = '{1'b1, 32'h400, 32'h11223344, 4'b1111, 4, 32'h00000000, 1'b1};
    tbl[10] = '{1'b0, 32'h000, 32'h0,        4'b1111, 4, 32'h0BADF00D, 1'b1};
    for (int i = 0; i < 11; i++) begin
      access(1, tbl[i].w, 1'b0, tbl[i].addr, tbl[i].data, tbl[i].be, stall, rd);
      chk($sformatf("tbl%0d_stall", i), stall, tbl[i].stall);
      chk($sformatf("tbl%0d_readdata", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d_err", i), {31'b0, berr[1]}, {31'b0, tbl[i].err});
    end

    @(negedge clk);
    sel = 2; address = 32'h20; writedata = 32'h0; byteenable = 4'hF; write = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    write = 1'b0;
    @(negedge clk);
    chk("abort_err", {31'b0, berr[2]}, 32'h1);
    access(2, 1'b0, 1'b0, 32'h20, 32'h0, 4'hF, stall, rd);
    chk("abort_no_effect", rd, 32'h01010101);
    chk("w5_stall", stall, 6);

    @(negedge clk);
    sel = 2; address = 32'h20; writedata = 32'hFFFFFFFF; byteenable = 4'hF; write = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_wait_waitreq", {31'b0, wreq[2]}, 32'h0);
    chk("rst_wait_readdata", rdata[2], 32'h0);
    chk("rst_wait_err", {31'b0, berr[2]}, 32'h0);
    access(2, 1'b0, 1'b0, 32'h20, 32'h0, 4'hF, stall, rd);
    chk("rst_wait_mem", rd, 32'h01010101);
    chk("rst_wait_idle_stall", stall, 6);

    m = 8'hA5;
    for (int i = 0; i < 20; i++) begin
      w = (m[3:0] > 4'd7) ? 7 : int'(m[3:0]);
      access(3, 1'b0, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 4'hF, stall, rd);
      chk($sformatf("rnd%0d_stall", i), stall, w + 1);
      chk($sformatf("rnd%0d_max", i), {31'b0, stall <= 8}, 32'h1);
      chk($sformatf("rnd%0d_data", i), rd, 32'hC0DE0000 | 32'(i));
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
